// File: rtl/div_clk_monitor_pkg.sv
// Shared types for the divided-clock monitor: FSM state encoding.
package div_clk_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus registered rise/fall detect.
// Also used by the button/key front end.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & last_q;
    end
  end

endmodule

// File: rtl/div_clk_monitor.sv
// Samples a slow square wave in the clk domain, emits edge ticks, measures the
// rise-to-rise period and tracks lock/loss of that period.
module div_clk_monitor
  import div_clk_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 1000,
  parameter int LOCK_EDGES  = 4,
  parameter int TOL         = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_in,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_stb,
  output logic                 locked,
  output logic                 lost_stb
);

  localparam int                   MW      = $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [MW-1:0]        LOCK_N  = MW'(LOCK_EDGES);

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] pcnt, prev, meas;
  logic [CNT_WIDTH:0]   diff;
  logic [MW-1:0]        match, match_n, match_calc;
  logic                 first, enter_acq, do_meas, too_far, timeout;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (clk_in),
    .rise (rise_tick),
    .fall (fall_tick)
  );

  // meas counts the rise_tick cycle itself, hence pcnt+1
  assign meas    = (pcnt == CNT_MAX) ? CNT_MAX : pcnt + CNT_WIDTH'(1);
  assign diff    = ({1'b0, meas} >= {1'b0, prev}) ? {1'b0, meas} - {1'b0, prev}
                                                  : {1'b0, prev} - {1'b0, meas};
  assign too_far = diff > (CNT_WIDTH + 1)'(TOL);
  assign timeout = (pcnt == TO_LAST) && !rise_tick;
  assign match_calc = (first || too_far) ? MW'(1) : match + MW'(1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    match_n   = match;
    enter_acq = 1'b0;
    do_meas   = 1'b0;
    lost_stb  = 1'b0;
    case (state)
      ST_IDLE, ST_LOST: begin
        if (rise_tick) begin
          state_n   = ST_ACQ;
          enter_acq = 1'b1;
        end
      end
      ST_ACQ: begin
        if (rise_tick) begin
          do_meas = 1'b1;
          match_n = match_calc;
          if (match_calc == LOCK_N) state_n = ST_LOCKED;
        end else if (timeout) begin
          state_n  = ST_LOST;
          lost_stb = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (rise_tick) begin
          do_meas = 1'b1;
          if (too_far) begin
            state_n = ST_ACQ;
            match_n = MW'(1);
          end
        end else if (timeout) begin
          state_n  = ST_LOST;
          lost_stb = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pcnt       <= '0;
      prev       <= '0;
      match      <= '0;
      first      <= 1'b0;
      period_o   <= '0;
      period_stb <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      pcnt       <= rise_tick ? '0 : meas;
      match      <= match_n;
      period_stb <= do_meas;
      locked     <= (state_n == ST_LOCKED);
      if (enter_acq)    first <= 1'b1;
      else if (do_meas) first <= 1'b0;
      if (do_meas) begin
        period_o <= meas;
        prev     <= meas;
      end
    end
  end

endmodule
